mcp_datapath: RTL

//  Multicycle MIPS datapath: the responder driven by the multicycle controller.

---
 rtl/mcp_datapath.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mcp_datapath.sv
// -----------------------------------------------------------------------------
// mcp_datapath
//
// Multicycle MIPS datapath. This block is driven by the multicycle controller:
// it takes the controller's strobes and selects, and returns op, funct and zero
// to it. It holds the architectural and inter-cycle registers (PC, IR, MDR, A,
// B, ALUOut) and a 32 x 32 register file. It also drives one unified
// instruction/data memory port.
//
// Parameters
//   WIDTH     datapath width (only 32 is meaningful for MIPS encodings)
//   RESET_PC  value loaded into PC while reset is asserted
//
// Ports
//   clk         clock; every register updates on the rising edge
//   reset       asynchronous, active-high; clears all state, loads RESET_PC
//   pcen        PC load enable (the controller has already folded branch&zero in)
//   irwrite     IR load enable
//   regwrite    register-file write enable
//   alusrca     0: srcA = PC,      1: srcA = A
//   iord        0: adr = PC,       1: adr = ALUOut
//   memtoreg    0: wd3 = ALUOut,   1: wd3 = MDR
//   regdst      0: wa3 = IR[20:16], 1: wa3 = IR[15:11]
//   alusrcb     00 B, 01 4, 10 sext(imm), 11 sext(imm) << 2
//   pcsrc       00 ALU result, 01 ALUOut, 10 jump target, 11 hold PC
//   alucontrol  010 add, 110 sub, 000 and, 001 or, 111 slt (others give 0)
//   readdata    memory read data for the current adr
//   op          IR[31:26]
//   funct       IR[5:0]
//   zero        ALU result == 0, combinational from the current selects
//   adr         memory address
//   writedata   memory write data (the B register)
// -----------------------------------------------------------------------------
module mcp_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] readdata,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);

  // ALU operation encodings as issued by the controller
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] ir_reg;
  logic [WIDTH-1:0] mdr_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] aluout_reg;
  logic [WIDTH-1:0] rf [32];

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       wa3;
  logic [WIDTH-1:0] wd3;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] imm_sh2;
  logic [WIDTH-1:0] jump_target;

  assign rs = ir_reg[25:21];
  assign rt = ir_reg[20:16];
  assign rd = ir_reg[15:11];

  assign wa3 = regdst   ? rd      : rt;
  assign wd3 = memtoreg ? mdr_reg : aluout_reg;

  // Sign extension replicates IR[15]; the word shift drops the top two bits.
  assign imm_ext = {{(WIDTH-16){ir_reg[15]}}, ir_reg[15:0]};
  assign imm_sh2 = {imm_ext[WIDTH-3:0], 2'b00};

  // Jump keeps the PC's top nibble as it stands at this edge. After a fetch
  // that already holds PC+4, which is the MIPS delay-slot-free semantics.
  assign jump_target = {pc_reg[WIDTH-1:WIDTH-4], ir_reg[25:0], 2'b00};

  // ---------------------------------------------------------------------------
  // Register file read ports (combinational from the current IR).
  // r0 is never written, but the explicit mux keeps it hard-wired to zero
  // independently of what the storage holds.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  assign rd1 = (rs == 5'd0) ? '0 : rf[rs];
  assign rd2 = (rt == 5'd0) ? '0 : rf[rt];

  // ---------------------------------------------------------------------------
  // ALU operand selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  assign src_a = alusrca ? a_reg : pc_reg;

  always_comb begin
    src_b = b_reg;
    case (alusrcb)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = WIDTH'(4);
      2'b10:   src_b = imm_ext;
      2'b11:   src_b = imm_sh2;
      default: src_b = b_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU. Add/sub wrap modulo 2^WIDTH with no overflow reporting; slt compares
  // as signed. Codes the controller never issues yield zero.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] alu_result;
  logic             slt_bit;

  assign slt_bit = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = '0;
    case (alucontrol)
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    case (pcsrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = aluout_reg;
      2'b10:   pc_next = jump_target;
      2'b11:   pc_next = pc_reg;
      default: pc_next = pc_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // A and B always sample the register file through the read ports, so on an
  // edge that also writes the file they capture the old value (no bypass).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      ir_reg     <= '0;
      mdr_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      aluout_reg <= '0;
    end else begin
      if (pcen) begin
        pc_reg <= pc_next;
      end
      if (irwrite) begin
        ir_reg <= readdata;
      end
      mdr_reg    <= readdata;
      a_reg      <= rd1;
      b_reg      <= rd2;
      aluout_reg <= alu_result;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file storage. The whole file clears on reset, so it is held in
  // flops rather than a RAM macro. Writes aimed at r0 are discarded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (regwrite && (wa3 != 5'd0)) begin
      rf[wa3] <= wd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign op        = ir_reg[31:26];
  assign funct     = ir_reg[5:0];
  assign adr       = iord ? aluout_reg : pc_reg;
  assign writedata = b_reg;

endmodule
